// File: rtl/dma_service_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// dmaSeqPkg
// Shared definitions for the DMA service sequencer:
//   - dma_state_e     : sequencer FSM states (IDLE, REQ, GRANT, XFER, DONE)
//   - NUM_CH_DEFAULT  : default number of DMA channels
//   - PRIO_FIXED / PRIO_ROTATING : encoding of the priorityType command bit
// Configuration macro: DMA_ROTATING_PRIORITY_EN (consumed by the top level).
// ----------------------------------------------------------------------------
package dmaSeqPkg;

  localparam int NUM_CH_DEFAULT = 4;

  localparam logic PRIO_FIXED    = 1'b0;
  localparam logic PRIO_ROTATING = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    GRANT = 3'd2,
    XFER  = 3'd3,
    DONE  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_priority_resolver.sv
// ----------------------------------------------------------------------------
// dma_priority_resolver
// Combinational channel arbiter.
//   pending      in  NUM_CH  unmasked requests
//   lastServed   in  IDX_W   channel served most recently (rotating mode)
//   priorityType in  1       PRIO_FIXED: ch0 highest; PRIO_ROTATING: the
//                            channel after lastServed is highest
//   winner       out IDX_W   index of the highest-priority pending channel
//   valid        out 1       at least one channel is pending
// ----------------------------------------------------------------------------
module dma_priority_resolver
  import dmaSeqPkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEFAULT,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [IDX_W-1:0]  lastServed,
  input  logic              priorityType,
  output logic [IDX_W-1:0]  winner,
  output logic              valid
);

  int               start_idx;
  logic [IDX_W-1:0] idx_v;

  // Scan from the lowest-priority slot up to the highest so that the last
  // hit (the highest-priority pending channel) is the one that sticks.
  always_comb begin
    winner    = '0;
    valid     = 1'b0;
    idx_v     = '0;
    start_idx = (priorityType == PRIO_ROTATING) ? ((int'(lastServed) + 1) % NUM_CH) : 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx_v = IDX_W'((start_idx + k) % NUM_CH);
      if (pending[idx_v]) begin
        winner = idx_v;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_service_sequencer.sv
// ----------------------------------------------------------------------------
// dma_service_sequencer
// Timing-and-control sequencer of the DMA controller: arbitrates channel
// requests, runs the HRQ/HLDA bus-hold handshake, drives a single DACK and
// paces one xferValid strobe per transfer until TC, external EOP or request
// withdrawal.
//
// Ports:
//   CLK          in   system clock (posedge)
//   RESET        in   synchronous, active-high reset
//   DREQ         in   NUM_CH channel requests
//   maskReg      in   NUM_CH per-channel mask (1 = excluded)
//   priorityType in   0 = fixed, 1 = rotating
//   demandMode   in   NUM_CH per-channel mode (1 = demand, 0 = single)
//   HLDA         in   CPU hold acknowledge
//   tcReached    in   current transfer is the last one
//   extEOP       in   external end-of-process request
//   HRQ          out  hold request to the CPU
//   DACK         out  NUM_CH one-hot acknowledge
//   activeCh     out  granted channel index
//   xferValid    out  one strobe per transfer
//   EOP          out  one-cycle termination pulse (TC or extEOP)
//   dbg_state    out  current FSM state
//
// Handshake: HRQ is held from REQ through XFER; the CPU grants the bus by
// raising HLDA. HLDA low while in GRANT/XFER aborts to IDLE on the next edge
// with no EOP and no update of the rotating pointer.
//
// Configuration macro: DMA_ROTATING_PRIORITY_EN
//   defined   : priorityType selects fixed/rotating; lastServed register kept
//   undefined : fixed priority only; priorityType ignored
// ----------------------------------------------------------------------------
module dma_service_sequencer
  import dmaSeqPkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEFAULT,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              priorityType,
  input  logic [NUM_CH-1:0] demandMode,
  input  logic              HLDA,
  input  logic              tcReached,
  input  logic              extEOP,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [IDX_W-1:0]  activeCh,
  output logic              xferValid,
  output logic              EOP,
  output dma_state_e        dbg_state
);

  dma_state_e        state, next_state;
  logic [NUM_CH-1:0] pending;
  logic [IDX_W-1:0]  active_q;
  logic [IDX_W-1:0]  last_served;
  logic [IDX_W-1:0]  winner;
  logic              winner_valid;
  logic              prio_sel;
  logic              end_hit;
  logic              eop_flag;

  assign pending = DREQ & ~maskReg;
  assign end_hit = tcReached | extEOP;

`ifdef DMA_ROTATING_PRIORITY_EN
  logic [IDX_W-1:0] last_served_q;

  // Pointer moves only on a completed service (entry to DONE), never on abort.
  always_ff @(posedge CLK) begin
    if (RESET)
      last_served_q <= IDX_W'(NUM_CH - 1);
    else if (state == XFER && next_state == DONE)
      last_served_q <= active_q;
  end

  assign last_served = last_served_q;
  assign prio_sel    = priorityType;
`else
  logic unused_priority_type;

  assign unused_priority_type = priorityType;
  assign last_served          = IDX_W'(NUM_CH - 1);
  assign prio_sel             = PRIO_FIXED;
`endif

  dma_priority_resolver #(.NUM_CH(NUM_CH)) u_resolver (
    .pending      (pending),
    .lastServed   (last_served),
    .priorityType (prio_sel),
    .winner       (winner),
    .valid        (winner_valid)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (winner_valid) next_state = REQ;
      REQ: begin
        if (!winner_valid)  next_state = IDLE;
        else if (HLDA)      next_state = GRANT;
      end
      GRANT: next_state = HLDA ? XFER : IDLE;
      XFER: begin
        if (!HLDA)                        next_state = IDLE;
        else if (end_hit)                 next_state = DONE;
        else if (!demandMode[active_q])   next_state = DONE;
        else if (DREQ[active_q])          next_state = XFER;
        else                              next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Granted channel is frozen at the REQ->GRANT edge; later mask or request
  // changes on other channels cannot move it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      active_q <= '0;
      eop_flag <= 1'b0;
    end else begin
      if (state == REQ && next_state == GRANT)
        active_q <= winner;
      eop_flag <= (state == XFER) && (next_state == DONE) && end_hit;
    end
  end

  // Moore outputs
  always_comb begin
    HRQ       = 1'b0;
    DACK      = '0;
    xferValid = 1'b0;
    EOP       = 1'b0;
    case (state)
      REQ: HRQ = 1'b1;
      GRANT: begin
        HRQ            = 1'b1;
        DACK[active_q] = 1'b1;
      end
      XFER: begin
        HRQ            = 1'b1;
        DACK[active_q] = 1'b1;
        xferValid      = 1'b1;
      end
      DONE:    EOP = eop_flag;
      default: ;
    endcase
  end

  assign activeCh  = active_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_dma_service_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dma_service_sequencer
// Directed steps followed by randomized transactions. Expected grants come
// from a priority-order model of the arbitration rules; expected strobe and
// EOP counts come from the termination rules.
// ----------------------------------------------------------------------------
module tb_dma_service_sequencer;
  import dmaSeqPkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DREQ = '0;
  logic [3:0] maskReg = '0;
  logic       priorityType = 1'b0;
  logic [3:0] demandMode = '0;
  logic       HLDA = 1'b0;
  logic       tcReached = 1'b0;
  logic       extEOP = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeCh;
  logic       xferValid;
  logic       EOP;
  dma_state_e dbg_state;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  int         model_last = 3;
  bit         started = 1'b0;

  dma_service_sequencer #(.NUM_CH(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DREQ         (DREQ),
    .maskReg      (maskReg),
    .priorityType (priorityType),
    .demandMode   (demandMode),
    .HLDA         (HLDA),
    .tcReached    (tcReached),
    .extEOP       (extEOP),
    .HRQ          (HRQ),
    .DACK         (DACK),
    .activeCh     (activeCh),
    .xferValid    (xferValid),
    .EOP          (EOP),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Single-DACK property, sampled away from the active edge.
  always @(negedge CLK) begin
    if (started && !RESET) begin
      checks++;
      assert ($onehot0(DACK)) else begin
        errors++;
        $error("FAIL dack_onehot0: observed %b required at most one bit", DACK);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rot_eff(input logic prio);
`ifdef DMA_ROTATING_PRIORITY_EN
    return prio;
`else
    return 1'b0;
`endif
  endfunction

  // Priority order list: fixed is 0,1,2,3; rotating starts after last served.
  function automatic int model_winner(input logic [3:0] pend, input int last, input bit rot);
    int order[4];
    for (int k = 0; k < 4; k++) order[k] = rot ? (last + 1 + k) % 4 : k;
    for (int k = 0; k < 4; k++) if (pend[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    model_last = 3;
  endtask

  // One full service: request, handshake, strobes, termination.
  task automatic run_txn(input logic [3:0] req, input logic [3:0] mask, input logic [3:0] dem,
                         input logic prio, input int tc_at, input int drop_at,
                         input bit use_ext, input bit both, output int granted);
    int         exp_ch, exp_strobes, exp_eops, strobes, eops, waited;
    bit         done;
    logic [1:0] exp_g;
    exp_ch = model_winner(req & ~mask, model_last, rot_eff(prio));
    exp_q.push_back(exp_ch[1:0]);
    if (dem[exp_ch]) begin
      exp_strobes = (tc_at < drop_at) ? tc_at : drop_at;
      exp_eops    = (tc_at <= drop_at) ? 1 : 0;
    end else begin
      exp_strobes = 1;
      exp_eops    = (tc_at == 1) ? 1 : 0;
    end
    DREQ = req; maskReg = mask; demandMode = dem; priorityType = prio;
    waited = 0;
    while (HRQ !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    chk("hrq_rise", HRQ, 1);
    tick();
    HLDA = 1'b1;
    tick();
    exp_g = exp_q.pop_front();
    granted = int'(activeCh);
    chk("dack_grant", DACK, 32'(4'b0001 << exp_g));
    chk("active_ch", activeCh, exp_g);
    chk("no_strobe_in_grant", xferValid, 0);
    strobes = 0; eops = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (xferValid) begin
        strobes++;
        if (strobes == tc_at) begin
          tcReached = !use_ext || both;
          extEOP    = use_ext || both;
        end else begin
          tcReached = 1'b0;
          extEOP    = 1'b0;
        end
        if (strobes == drop_at) DREQ = '0;
      end else begin
        tcReached = 1'b0;
        extEOP    = 1'b0;
      end
      if (EOP) eops++;
      if (!HRQ) begin
        done = 1'b1;
        DREQ = '0;
        chk("dack_low_on_done", DACK, 0);
      end
    end
    chk("txn_done", done, 1);
    chk("strobe_count", strobes, exp_strobes);
    chk("eop_count", eops, exp_eops);
    HLDA = 1'b0; tcReached = 1'b0; extEOP = 1'b0;
    tick();
    chk("eop_one_cycle", EOP, 0);
    chk("idle_gap", dbg_state, IDLE);
    tick();
    if (done) model_last = exp_ch;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         g;
    int         hrq_seen;
    int         exp_rot[3];
    logic [3:0] r_req, r_mask, r_dem;

    do_reset();
    started = 1'b1;
    chk("rst_hrq", HRQ, 0);
    chk("rst_dack", DACK, 0);
    chk("rst_xfer", xferValid, 0);
    chk("rst_eop", EOP, 0);
    chk("rst_active", activeCh, 0);
    chk("rst_state", dbg_state, IDLE);

    // Fixed priority, single mode: ch1 wins over ch2/ch3.
    run_txn(4'b1110, 4'b0000, 4'b0000, 1'b0, 9, 9, 1'b0, 1'b0, g);
    chk("fixed_winner", g, 1);

    // Rotating sequence after serving ch1.
`ifdef DMA_ROTATING_PRIORITY_EN
    exp_rot = '{2, 3, 0};
`else
    exp_rot = '{0, 0, 0};
`endif
    for (int i = 0; i < 3; i++) begin
      run_txn(4'b1111, 4'b0000, 4'b0000, 1'b1, 9, 9, 1'b0, 1'b0, g);
      chk("rotate_seq", g, exp_rot[i]);
    end

    // Demand mode ch2, TC on the third strobe while DREQ is held for five.
    run_txn(4'b0100, 4'b0000, 4'b0100, 1'b0, 3, 5, 1'b0, 1'b0, g);
    chk("demand_ch", g, 2);

    // Simultaneous TC and extEOP yield a single pulse.
    run_txn(4'b1000, 4'b0000, 4'b1000, 1'b0, 2, 6, 1'b0, 1'b1, g);

    // Demand mode ended by request withdrawal: no EOP.
    run_txn(4'b0010, 4'b0000, 4'b0010, 1'b0, 6, 4, 1'b0, 1'b0, g);

    // Masked-only request never raises HRQ.
    DREQ = 4'b0001; maskReg = 4'b0001;
    hrq_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (HRQ) hrq_seen++;
    end
    chk("mask_no_hrq", hrq_seen, 0);
    chk("mask_idle", dbg_state, IDLE);
    DREQ = '0; maskReg = '0;
    tick();

    // HLDA dropped mid-XFER: abort next cycle, no EOP, pointer untouched.
    DREQ = 4'b1000; demandMode = 4'b1000; priorityType = 1'b0;
    tick();
    tick();
    HLDA = 1'b1;
    tick();
    chk("abort_grant", DACK, 4'b1000);
    tick();
    chk("abort_strobe1", xferValid, 1);
    tick();
    chk("abort_strobe2", xferValid, 1);
    HLDA = 1'b0; DREQ = '0;
    tick();
    chk("abort_state", dbg_state, IDLE);
    chk("abort_dack", DACK, 0);
    chk("abort_hrq", HRQ, 0);
    chk("abort_eop", EOP, 0);
    tick();
    chk("abort_no_late_eop", EOP, 0);
    run_txn(4'b1111, 4'b0000, 4'b0000, 1'b1, 9, 9, 1'b0, 1'b0, g);

    // RESET in XFER with HLDA still high.
    DREQ = 4'b0100; demandMode = 4'b0100;
    tick();
    tick();
    HLDA = 1'b1;
    tick();
    tick();
    chk("pre_reset_xfer", xferValid, 1);
    RESET = 1'b1;
    tick();
    chk("reset_hrq", HRQ, 0);
    chk("reset_dack", DACK, 0);
    chk("reset_xfer", xferValid, 0);
    chk("reset_eop", EOP, 0);
    chk("reset_active", activeCh, 0);
    RESET = 1'b0; HLDA = 1'b0; DREQ = '0;
    model_last = 3;
    tick();

    // Randomized services.
    for (int t = 0; t < 40; t++) begin
      r_req  = 4'($urandom_range(1, 15));
      r_mask = 4'($urandom_range(0, 15));
      if ((r_req & ~r_mask) == 4'b0000) r_mask = 4'b0000;
      r_dem  = 4'($urandom_range(0, 15));
      run_txn(r_req, r_mask, r_dem, 1'($urandom_range(0, 1)),
              $urandom_range(1, 6), $urandom_range(1, 6),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
